// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial adder/subtractor.
// One full-adder slice and a registered carry process WIDTH-bit operands
// LSB first, one bit per clock, behind a start/busy/done handshake.
// Subtraction is a + ~b + 1; the signed-overflow flag compares the carry
// into the MSB with the carry out of it.
module serial_adder_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Counter value seen on the edge that processes the MSB.
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // One-bit full adder; returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
      full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
   endfunction

   logic [0:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] psum_q,   psum_d;
   logic             carry_q,  carry_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic [1:0]       slice;
   logic             slice_sum;
   logic             slice_cout;

   assign slice      = full_add(a_sh_q[0], b_sh_q[0], carry_q);
   assign slice_sum  = slice[0];
   assign slice_cout = slice[1];

   // Next-state logic: operand capture in IDLE, one bit per edge in RUN.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               psum_d  = {WIDTH{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            psum_d  = {slice_sum, psum_q[WIDTH-1:1]};
            carry_d = slice_cout;
            if (cnt_q == LAST_BIT) begin
               // MSB edge: carry_q is the carry into the MSB here.
               sum_d   = {slice_sum, psum_q[WIDTH-1:1]};
               cout_d  = slice_cout;
               ovf_d   = carry_q ^ slice_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sh_q  <= {WIDTH{1'b0}};
         b_sh_q  <= {WIDTH{1'b0}};
         psum_q  <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         psum_q  <= psum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=8 scenarios plus an exhaustive
// WIDTH=3 sweep against a small arithmetic reference.
module tb_serial_adder_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       cin = 1'b0;
   logic       sub = 1'b0;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   logic       start3 = 1'b0;
   logic [2:0] a3 = 3'd0;
   logic [2:0] b3 = 3'd0;
   logic       cin3 = 1'b0;
   logic       sub3 = 1'b0;
   logic       busy3, done3, cout3, ovf3;
   logic [2:0] sum3;

   int vec_cnt = 0;
   int err_cnt = 0;
   int done3_cnt = 0;

   serial_adder_n #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_adder_n #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3), .sub(sub3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
   );

   always #5 clk = ~clk;

   // count every done pulse of the WIDTH=3 instance
   always @(posedge clk) begin
      if (done3 === 1'b1) done3_cnt <= done3_cnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Launch one WIDTH=8 operation and report what came back.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                        input logic tsub, output int lat, output logic [7:0] rs,
                        output logic rc, output logic ro, output logic dafter);
      a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      rs = sum; rc = cout; ro = ovf;
      tick();
      dafter = done;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         vec_cnt++;
         if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_idle cyc %0d: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     i, busy, done, sum, cout, ovf);
         end
      end
      vec_cnt++;
      if ({busy3, done3, sum3, cout3, ovf3} !== 7'h00) begin
         err_cnt++;
         $display("FAIL reset_w3: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy3, done3, sum3, cout3, ovf3);
      end
   endtask

   task automatic test_addsub;
      logic [7:0] ta [5];
      logic [7:0] tbv [5];
      logic       tc [5];
      logic       ts [5];
      logic [7:0] es [5];
      logic       ec [5];
      logic       eo [5];
      int lat; logic [7:0] rs; logic rc, ro, da;
      ta  = '{8'hFF, 8'h7F, 8'h0F, 8'h05, 8'h80};
      tbv = '{8'h01, 8'h01, 8'h10, 8'h07, 8'h01};
      tc  = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
      ts  = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
      es  = '{8'h00, 8'h80, 8'h20, 8'hFE, 8'h7F};
      ec  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
      eo  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
      for (int i = 0; i < 5; i++) begin
         do_op(ta[i], tbv[i], tc[i], ts[i], lat, rs, rc, ro, da);
         vec_cnt++;
         if (lat !== 8) begin
            err_cnt++;
            $display("FAIL op%0d_latency: got %0d expected 8", i, lat);
         end
         vec_cnt++;
         if (rs !== es[i]) begin
            err_cnt++;
            $display("FAIL op%0d_sum: got %h expected %h", i, rs, es[i]);
         end
         vec_cnt++;
         if (rc !== ec[i]) begin
            err_cnt++;
            $display("FAIL op%0d_cout: got %b expected %b", i, rc, ec[i]);
         end
         vec_cnt++;
         if (ro !== eo[i]) begin
            err_cnt++;
            $display("FAIL op%0d_ovf: got %b expected %b", i, ro, eo[i]);
         end
         vec_cnt++;
         if (da !== 1'b0) begin
            err_cnt++;
            $display("FAIL op%0d_done_width: done=%b one cycle after pulse, expected 0", i, da);
         end
      end
   endtask

   task automatic test_back_to_back;
      int cyc; int gap; int extra;
      a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      a = 8'hFF; b = 8'hFF;
      tick(); tick();
      start = 1'b0;
      cyc = 2;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      vec_cnt++;
      if (cyc !== 8) begin
         err_cnt++;
         $display("FAIL hs_first_latency: got %0d expected 8", cyc);
      end
      vec_cnt++;
      if (sum !== 8'h03) begin
         err_cnt++;
         $display("FAIL hs_first_sum: got %h expected 03", sum);
      end
      a = 8'h10; b = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      gap = 1;
      while (done !== 1'b1 && gap < 40) begin
         tick();
         gap++;
      end
      vec_cnt++;
      if (gap !== 9) begin
         err_cnt++;
         $display("FAIL hs_second_gap: got %0d expected 9", gap);
      end
      vec_cnt++;
      if (sum !== 8'h30) begin
         err_cnt++;
         $display("FAIL hs_second_sum: got %h expected 30", sum);
      end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) extra++;
      end
      vec_cnt++;
      if (extra !== 0) begin
         err_cnt++;
         $display("FAIL hs_extra_done: got %0d extra pulses expected 0", extra);
      end
   endtask

   task automatic test_reset_mid_op;
      int lat; logic [7:0] rs; logic rc, ro, da; int seen;
      a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec_cnt++;
      if ({busy, done, sum, cout, ovf} !== 12'h000) begin
         err_cnt++;
         $display("FAIL midrst_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy, done, sum, cout, ovf);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      vec_cnt++;
      if (seen !== 0) begin
         err_cnt++;
         $display("FAIL midrst_no_done: got %0d busy/done cycles expected 0", seen);
      end
      do_op(8'h01, 8'h01, 1'b0, 1'b0, lat, rs, rc, ro, da);
      vec_cnt++;
      if (lat !== 8 || rs !== 8'h02) begin
         err_cnt++;
         $display("FAIL midrst_recover: got lat=%0d sum=%h expected lat=8 sum=02", lat, rs);
      end
   endtask

   task automatic test_exhaustive_w3;
      int base; int cyc;
      logic [2:0] bb;
      logic [3:0] full;
      logic       exp_o;
      base = done3_cnt;
      for (int i = 0; i < 128; i++) begin
         a3 = 3'(i); b3 = 3'(i >> 3); sub3 = i[6]; cin3 = i[0] ^ i[3];
         start3 = 1'b1;
         tick();
         start3 = 1'b0;
         cyc = 0;
         while (done3 !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
         end
         bb    = sub3 ? ~b3 : b3;
         full  = {1'b0, a3} + {1'b0, bb} + (sub3 ? 4'd1 : {3'b000, cin3});
         exp_o = (a3[2] == bb[2]) && (full[2] != a3[2]);
         vec_cnt++;
         if (cyc !== 3 || sum3 !== full[2:0] || cout3 !== full[3] || ovf3 !== exp_o) begin
            err_cnt++;
            $display("FAIL w3 a=%0d b=%0d cin=%b sub=%b: got lat=%0d sum=%0d cout=%b ovf=%b expected lat=3 sum=%0d cout=%b ovf=%b",
                     a3, b3, cin3, sub3, cyc, sum3, cout3, ovf3, full[2:0], full[3], exp_o);
         end
      end
      tick(); tick(); tick();
      vec_cnt++;
      if (done3_cnt - base !== 128) begin
         err_cnt++;
         $display("FAIL w3_done_count: got %0d expected 128", done3_cnt - base);
      end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_back_to_back();
      test_reset_mid_op();
      test_exhaustive_w3();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
